// File: rtl/exu_lsu_pkg.sv
// Shared types and helpers for the EXU load/store unit: FSM state encoding,
// default timeout width and small decode functions.
package exu_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_CMD  = 3'd1,
    LSU_RSP  = 3'd2,
    LSU_NOP  = 3'd3,
    LSU_ERR  = 3'd4
  } lsu_state_e;

  localparam int LSU_TMO_W_DEF = 8;

  // Exactly one of load / store is requested.
  function automatic logic op_legal(input logic ren, input logic [3:0] wen);
    return ren ^ (wen != 4'b0000);
  endfunction

  // Byte address to word-aligned address.
  function automatic logic [31:0] word_adr(input logic [31:0] adr);
    return adr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/exu_lsu.sv
// Load/store unit: captures one EXU memory op, issues it on a valid/ready
// command/response bus and returns the result with a one-cycle ready pulse.
module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int TMO_W = LSU_TMO_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ex4ls_val,
  output logic        hs_ls4ex_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_bus_cmd_val,
  input  logic        i_bus_cmd_rdy,
  output logic [31:0] o_bus_cmd_adr,
  output logic        o_bus_cmd_read,
  output logic [31:0] o_bus_cmd_wdat,
  output logic [3:0]  o_bus_cmd_wmsk,
  input  logic        i_bus_rsp_val,
  output logic        o_bus_rsp_rdy,
  input  logic [31:0] i_bus_rsp_rdat,
  input  logic        i_bus_rsp_err
);

  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  lsu_state_e       state_r;
  lsu_state_e       state_nxt_s;
  logic [31:0]      adr_r;
  logic [31:0]      wdat_r;
  logic [3:0]       wen_r;
  logic             ren_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             tmo_hit_s;
  logic             capture_s;
  logic             rsp_done_s;

  assign capture_s  = (state_r == LSU_IDLE) && hs_ex4ls_val;
  // Once the counter has reached its last step any cycle without the exiting
  // handshake aborts; a command accepted at that step still gets one RSP cycle.
  assign tmo_hit_s  = (tmo_cnt_r >= TMO_LAST);
  assign rsp_done_s = (state_r == LSU_RSP) && i_bus_rsp_val;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (!hs_ex4ls_val) begin
          state_nxt_s = LSU_IDLE;
        end else if (op_legal(i_ls_ren, i_ls_wen)) begin
          state_nxt_s = LSU_CMD;
        end else if (i_ls_ren) begin
          state_nxt_s = LSU_ERR;
        end else begin
          state_nxt_s = LSU_NOP;
        end
      end
      LSU_CMD: begin
        if (i_bus_cmd_rdy) begin
          state_nxt_s = LSU_RSP;
        end else if (tmo_hit_s) begin
          state_nxt_s = LSU_ERR;
        end else begin
          state_nxt_s = LSU_CMD;
        end
      end
      LSU_RSP: begin
        if (i_bus_rsp_val) begin
          state_nxt_s = LSU_IDLE;
        end else if (tmo_hit_s) begin
          state_nxt_s = LSU_ERR;
        end else begin
          state_nxt_s = LSU_RSP;
        end
      end
      LSU_NOP: state_nxt_s = LSU_IDLE;
      LSU_ERR: state_nxt_s = LSU_IDLE;
      default: state_nxt_s = LSU_IDLE;
    endcase
  end

  // Request capture; the bank only loads in IDLE so EXU inputs are ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_r  <= 32'h0000_0000;
      wdat_r <= 32'h0000_0000;
      wen_r  <= 4'b0000;
      ren_r  <= 1'b0;
    end else if (capture_s) begin
      adr_r  <= i_ls_adr;
      wdat_r <= i_ls_wdat;
      wen_r  <= i_ls_wen;
      ren_r  <= i_ls_ren;
    end else begin
      adr_r  <= adr_r;
      wdat_r <= wdat_r;
      wen_r  <= wen_r;
      ren_r  <= ren_r;
    end
  end

  // Saturating timeout counter over the CMD+RSP window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (capture_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (((state_r == LSU_CMD) || (state_r == LSU_RSP)) && (tmo_cnt_r != TMO_MAX)) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign o_bus_cmd_val  = (state_r == LSU_CMD);
  assign o_bus_cmd_adr  = word_adr(adr_r);
  assign o_bus_cmd_read = ren_r;
  assign o_bus_cmd_wdat = wdat_r;
  assign o_bus_cmd_wmsk = ren_r ? 4'b0000 : wen_r;
  assign o_bus_rsp_rdy  = (state_r == LSU_RSP);

  // Completion is combinational on the response so the minimum latency is two cycles.
  assign hs_ls4ex_rdy = rsp_done_s || (state_r == LSU_NOP) || (state_r == LSU_ERR);
  assign o_ls_rdat    = (rsp_done_s && ren_r) ? i_bus_rsp_rdat : 32'h0000_0000;
  assign o_ls_err     = (state_r == LSU_ERR) || (rsp_done_s && i_bus_rsp_err);

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: directed scenarios plus randomized ops,
// each judged against a transaction-level timing/result model.
module tb_exu_lsu;

  localparam int TMO_W    = 3;
  localparam int TMO_CYC  = 7;
  localparam int LAST_IDX = TMO_CYC - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_ex4ls_val;
  logic        hs_ls4ex_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_bus_cmd_val;
  logic        i_bus_cmd_rdy;
  logic [31:0] o_bus_cmd_adr;
  logic        o_bus_cmd_read;
  logic [31:0] o_bus_cmd_wdat;
  logic [3:0]  o_bus_cmd_wmsk;
  logic        i_bus_rsp_val;
  logic        o_bus_rsp_rdy;
  logic [31:0] i_bus_rsp_rdat;
  logic        i_bus_rsp_err;

  int n_chk = 0;
  int n_bad = 0;
  int gcyc  = 0;
  int first_cmd_g;

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  exu_lsu #(.TMO_W(TMO_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hs_ex4ls_val   (hs_ex4ls_val),
    .hs_ls4ex_rdy   (hs_ls4ex_rdy),
    .i_ls_adr       (i_ls_adr),
    .i_ls_wdat      (i_ls_wdat),
    .i_ls_wen       (i_ls_wen),
    .i_ls_ren       (i_ls_ren),
    .o_ls_rdat      (o_ls_rdat),
    .o_ls_err       (o_ls_err),
    .o_bus_cmd_val  (o_bus_cmd_val),
    .i_bus_cmd_rdy  (i_bus_cmd_rdy),
    .o_bus_cmd_adr  (o_bus_cmd_adr),
    .o_bus_cmd_read (o_bus_cmd_read),
    .o_bus_cmd_wdat (o_bus_cmd_wdat),
    .o_bus_cmd_wmsk (o_bus_cmd_wmsk),
    .i_bus_rsp_val  (i_bus_rsp_val),
    .o_bus_rsp_rdy  (o_bus_rsp_rdy),
    .i_bus_rsp_rdat (i_bus_rsp_rdat),
    .i_bus_rsp_err  (i_bus_rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One op: present it in IDLE, act as a bus slave that accepts the command
  // after d1 stall cycles and answers after d2, then compare with the model.
  task automatic run_op(input string tag, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] wen, input logic ren, input int d1, input int d2,
                        input logic [31:0] rsp_dat, input logic rsp_e);
    bit          legal, normal;
    int          exp_done, exp_ncmd, exp_nrsp, rsp_start, rsp_lim;
    logic [31:0] exp_rdat;
    logic        exp_err;
    int          cyc = 0, k_cmd = 0, k_rsp = 0, n_cmd = 0, n_rsp = 0, done = -1;
    int          unstable = 0, stray = 0;
    logic [31:0] got_rdat = 32'h0;
    logic        got_err = 1'b0;

    legal = (ren == 1'b1) != (wen != 4'b0000);
    normal = 1'b0;
    exp_ncmd = 0;
    exp_nrsp = 0;
    if (!legal) begin
      exp_done = 1;
    end else if (d1 > LAST_IDX) begin
      exp_done = TMO_CYC + 1;
      exp_ncmd = TMO_CYC;
    end else begin
      exp_ncmd  = d1 + 1;
      rsp_start = d1 + 1;
      rsp_lim   = (rsp_start > LAST_IDX) ? rsp_start : LAST_IDX;
      normal    = (rsp_start + d2 <= rsp_lim);
      exp_done  = normal ? rsp_start + d2 + 1 : rsp_lim + 2;
      exp_nrsp  = normal ? d2 + 1 : rsp_lim - rsp_start + 1;
    end
    exp_err  = !legal ? ren : (normal ? rsp_e : 1'b1);
    exp_rdat = (normal && ren) ? rsp_dat : 32'h0;
    first_cmd_g = -1;

    hs_ex4ls_val = 1'b1;
    i_ls_adr = adr; i_ls_wdat = wdat; i_ls_wen = wen; i_ls_ren = ren;
    while (done < 0 && cyc < 20) begin
      i_bus_cmd_rdy  = 1'b0;
      i_bus_rsp_val  = 1'b0;
      i_bus_rsp_err  = 1'b0;
      i_bus_rsp_rdat = $urandom;
      if (o_bus_cmd_val) begin
        i_bus_cmd_rdy = (k_cmd == d1);
        k_cmd++;
      end
      if (o_bus_rsp_rdy) begin
        if (k_rsp == d2) begin
          i_bus_rsp_val = 1'b1; i_bus_rsp_rdat = rsp_dat; i_bus_rsp_err = rsp_e;
        end
        k_rsp++;
      end
      @(negedge clk);
      if (o_bus_cmd_val) begin
        if (n_cmd == 0) first_cmd_g = gcyc;
        n_cmd++;
        if (o_bus_cmd_adr !== (adr & 32'hFFFF_FFFC) || o_bus_cmd_read !== ren ||
            o_bus_cmd_wdat !== wdat || o_bus_cmd_wmsk !== (ren ? 4'b0000 : wen))
          unstable++;
      end
      if (o_bus_rsp_rdy) n_rsp++;
      if (hs_ls4ex_rdy) begin
        done = cyc; got_rdat = o_ls_rdat; got_err = o_ls_err;
      end else if (o_ls_rdat !== 32'h0 || o_ls_err !== 1'b0) begin
        stray++;
      end
      @(posedge clk); #1;
      cyc++;
      if (done < 0) begin
        i_ls_adr = $urandom; i_ls_wdat = $urandom;
        i_ls_wen = 4'($urandom); i_ls_ren = 1'($urandom);
      end
    end
    hs_ex4ls_val = 1'b0;
    i_bus_cmd_rdy = 1'b0; i_bus_rsp_val = 1'b0; i_bus_rsp_err = 1'b0;

    check_eq({tag, ".done_cyc"}, done, exp_done);
    check_eq({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
    check_eq({tag, ".rdat"}, got_rdat, exp_rdat);
    check_eq({tag, ".cmd_cycles"}, n_cmd, exp_ncmd);
    check_eq({tag, ".rsp_cycles"}, n_rsp, exp_nrsp);
    check_eq({tag, ".cmd_fields"}, unstable, 32'd0);
    check_eq({tag, ".idle_outs"}, stray, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".rdy"}, {31'b0, hs_ls4ex_rdy}, 32'd0);
    check_eq({tag, ".err"}, {31'b0, o_ls_err}, 32'd0);
    check_eq({tag, ".rdat"}, o_ls_rdat, 32'd0);
    check_eq({tag, ".cmd_val"}, {31'b0, o_bus_cmd_val}, 32'd0);
    check_eq({tag, ".rsp_rdy"}, {31'b0, o_bus_rsp_rdy}, 32'd0);
    check_eq({tag, ".cmd_adr"}, o_bus_cmd_adr, 32'd0);
    check_eq({tag, ".cmd_wdat"}, o_bus_cmd_wdat, 32'd0);
    check_eq({tag, ".cmd_wmsk"}, {28'b0, o_bus_cmd_wmsk}, 32'd0);
  endtask

  initial begin
    int g0, w;
    logic [3:0]  rw;
    logic        rr;
    int          kind;
    rst_n = 1'b0;
    hs_ex4ls_val = 1'b0;
    i_ls_adr = 32'h0; i_ls_wdat = 32'h0; i_ls_wen = 4'b0; i_ls_ren = 1'b0;
    i_bus_cmd_rdy = 1'b0; i_bus_rsp_val = 1'b0; i_bus_rsp_rdat = 32'h0; i_bus_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("load", 32'h0000_1006, 32'h0, 4'b0000, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0);
    run_op("store", 32'h0000_2000, 32'hAABB_0000, 4'b1100, 1'b0, 3, 0, 32'h1234_5678, 1'b0);
    run_op("buserr", 32'h0000_3008, 32'h0, 4'b0000, 1'b1, 0, 1, 32'hCAFE_F00D, 1'b1);
    run_op("tmo_cmd", 32'h0000_4000, 32'h0, 4'b0000, 1'b1, 50, 0, 32'h1111_1111, 1'b0);
    run_op("tmo_rsp", 32'h0000_4004, 32'h5555_AAAA, 4'b1111, 1'b0, 1, 50, 32'h0, 1'b0);
    run_op("cmd_at_limit", 32'h0000_4008, 32'h0, 4'b0000, 1'b1, 6, 0, 32'h7777_0001, 1'b0);
    run_op("illegal", 32'h0000_5000, 32'h0, 4'b0001, 1'b1, 0, 0, 32'h0, 1'b0);
    run_op("nop", 32'h0000_6000, 32'h0, 4'b0000, 1'b0, 0, 0, 32'h0, 1'b0);

    g0 = gcyc;
    run_op("b2b_a", 32'h0000_7000, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h0102_0304, 1'b0);
    run_op("b2b_b", 32'h0000_7004, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h0506_0708, 1'b0);
    check_eq("b2b.second_cmd_cycle", first_cmd_g - g0, 32'd4);

    // Reset while a load waits in RSP.
    hs_ex4ls_val = 1'b1; i_ls_adr = 32'h0000_8000; i_ls_wen = 4'b0000; i_ls_ren = 1'b1;
    w = 0;
    while (!o_bus_rsp_rdy && w < 10) begin
      i_bus_cmd_rdy = o_bus_cmd_val;
      @(posedge clk); #1;
      w++;
    end
    check_eq("midrst.reached_rsp", {31'b0, o_bus_rsp_rdy}, 32'd1);
    i_bus_cmd_rdy = 1'b0;
    hs_ex4ls_val = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_quiet("after_rst");
    run_op("post_rst", 32'h0000_9003, 32'h0, 4'b0000, 1'b1, 1, 1, 32'h9ABC_DEF0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rr = 1'b0;
      rw = 4'b0000;
      if (kind < 4) begin
        rr = 1'b1;
      end else if (kind < 8) begin
        rw = 4'($urandom_range(1, 15));
      end else if (kind == 8) begin
        rr = 1'b1; rw = 4'($urandom_range(1, 15));
      end
      run_op($sformatf("rnd%0d", i), $urandom, $urandom, rw, rr,
             $urandom_range(0, 8), $urandom_range(0, 6), $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
